// File: rtl/shift_reg_univ_if.sv
// Bundle of the control, data and status signals of the universal shift register.
// The master drives the controls and parallel data; the slave (the register) drives the status.
interface shift_reg_univ_if #(
  parameter int WIDTH = 8
) ();
  logic                             en;
  logic [1:0]                       mode;
  logic                             sin;
  logic [WIDTH-1:0]                 d;
  logic [WIDTH-1:0]                 q;
  logic                             sout_lsb;
  logic                             sout_msb;
  logic [$clog2(WIDTH+1)-1:0]       cnt;
  logic                             word_done;

  modport master (
    output en, mode, sin, d,
    input  q, sout_lsb, sout_msb, cnt, word_done
  );

  modport slave (
    input  en, mode, sin, d,
    output q, sout_lsb, sout_msb, cnt, word_done
  );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift right, shift left and parallel load, with a
// saturating shift counter and a one-cycle word-complete pulse. Reset is synchronous, active-low.
module shift_reg_univ #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  shift_reg_univ_if.slave   bus
);

  localparam int              CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [1:0]      MODE_HOLD = 2'b00;
  localparam logic [1:0]      MODE_SHR  = 2'b01;
  localparam logic [1:0]      MODE_SHL  = 2'b10;
  localparam logic [1:0]      MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             word_done_q, word_done_d;
  logic [WIDTH-1:0] shr_vec, shl_vec;
  logic             shift;

  // Shifted candidates: the vacated end takes sin, everything else moves one place.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi == WIDTH - 1) begin : g_shr_top
      assign shr_vec[gi] = bus.sin;
    end else begin : g_shr_mid
      assign shr_vec[gi] = q_q[gi+1];
    end
    if (gi == 0) begin : g_shl_bot
      assign shl_vec[gi] = bus.sin;
    end else begin : g_shl_mid
      assign shl_vec[gi] = q_q[gi-1];
    end
  end

  always_comb begin
    q_d         = q_q;
    cnt_d       = cnt_q;
    word_done_d = 1'b0;
    shift       = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_HOLD: q_d = q_q;
        MODE_SHR: begin
          q_d   = shr_vec;
          shift = 1'b1;
        end
        MODE_SHL: begin
          q_d   = shl_vec;
          shift = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = bus.d;
          cnt_d = '0;
        end
        default: q_d = q_q;
      endcase
    end
    // The pulse fires only on the shift that reaches WIDTH, so saturated shifts stay quiet.
    if (shift) begin
      if (cnt_q < CNT_FULL) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_q == CNT_LAST) begin
        word_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q         <= RST_VAL;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.sout_lsb  = q_q[0];
  assign bus.sout_msb  = q_q[WIDTH-1];
  assign bus.cnt       = cnt_q;
  assign bus.word_done = word_done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: a vector table on an 8-bit instance plus hand-written
// sequences for pulse width under enable gating and the 4-bit legacy chain equivalence.
module tb_shift_reg_univ;

  logic clk;
  logic rst;

  shift_reg_univ_if #(.WIDTH(8)) bus8 ();
  shift_reg_univ_if #(.WIDTH(4)) bus4 ();

  shift_reg_univ #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  shift_reg_univ #(.WIDTH(4), .RST_VAL(4'h0)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sin;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic [3:0] exp_cnt;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic s,
                     input logic [7:0] dd, input logic [7:0] eq, input logic [3:0] ec,
                     input logic ed);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.sin = s; v.d = dd;
    v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step8(input logic r, input logic e, input logic [1:0] m, input logic s,
                       input logic [7:0] dd);
    @(negedge clk);
    rst = r; bus8.en = e; bus8.mode = m; bus8.sin = s; bus8.d = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] eq, input logic [3:0] ec,
                        input logic ed);
    chk({tag, ".q"},         32'(bus8.q),         32'(eq));
    chk({tag, ".cnt"},       32'(bus8.cnt),       32'(ec));
    chk({tag, ".word_done"}, 32'(bus8.word_done), 32'(ed));
    chk({tag, ".sout_lsb"},  32'(bus8.sout_lsb),  32'(eq[0]));
    chk({tag, ".sout_msb"},  32'(bus8.sout_msb),  32'(eq[7]));
  endtask

  initial begin
    logic [7:0] lpat;
    rst = 1'b0;
    bus8.en = 1'b0; bus8.mode = 2'b00; bus8.sin = 1'b0; bus8.d = 8'h00;
    bus4.en = 1'b0; bus4.mode = 2'b10; bus4.sin = 1'b0; bus4.d = 4'h0;

    // Reset wins over an enabled load of 0xFF.
    add(0,1,2'b11,0,8'hFF, 8'hA5,0,0);
    add(0,1,2'b11,0,8'hFF, 8'hA5,0,0);
    // Load 0x81 then eight right shifts of 0.
    add(1,1,2'b11,0,8'h81, 8'h81,0,0);
    add(1,1,2'b01,0,8'h00, 8'h40,1,0);
    add(1,1,2'b01,0,8'h00, 8'h20,2,0);
    add(1,1,2'b01,0,8'h00, 8'h10,3,0);
    add(1,1,2'b01,0,8'h00, 8'h08,4,0);
    add(1,1,2'b01,0,8'h00, 8'h04,5,0);
    add(1,1,2'b01,0,8'h00, 8'h02,6,0);
    add(1,1,2'b01,0,8'h00, 8'h01,7,0);
    add(1,1,2'b01,0,8'h00, 8'h00,8,1);
    add(1,1,2'b00,0,8'h00, 8'h00,8,0);
    // Left-shift deserialize of 1,0,1,1,0,0,1,0 from reset, then saturation.
    add(0,1,2'b00,0,8'h00, 8'hA5,0,0);
    add(1,1,2'b10,1,8'h00, 8'h4B,1,0);
    add(1,1,2'b10,0,8'h00, 8'h96,2,0);
    add(1,1,2'b10,1,8'h00, 8'h2D,3,0);
    add(1,1,2'b10,1,8'h00, 8'h5B,4,0);
    add(1,1,2'b10,0,8'h00, 8'hB6,5,0);
    add(1,1,2'b10,0,8'h00, 8'h6C,6,0);
    add(1,1,2'b10,1,8'h00, 8'hD9,7,0);
    add(1,1,2'b10,0,8'h00, 8'hB2,8,1);
    add(1,1,2'b10,1,8'h00, 8'h65,8,0);
    add(1,1,2'b10,0,8'h00, 8'hCA,8,0);
    // Enable gating mid-word (cnt=3), then the word finishes with right shifts.
    add(1,1,2'b11,0,8'h00, 8'h00,0,0);
    add(1,1,2'b10,1,8'h00, 8'h01,1,0);
    add(1,1,2'b10,1,8'h00, 8'h03,2,0);
    add(1,1,2'b10,1,8'h00, 8'h07,3,0);
    add(1,0,2'b11,1,8'hFF, 8'h07,3,0);
    add(1,0,2'b01,0,8'hFF, 8'h07,3,0);
    add(1,0,2'b10,1,8'hFF, 8'h07,3,0);
    add(1,0,2'b11,0,8'hFF, 8'h07,3,0);
    add(1,0,2'b00,1,8'hFF, 8'h07,3,0);
    add(1,1,2'b01,0,8'h00, 8'h03,4,0);
    add(1,1,2'b01,0,8'h00, 8'h01,5,0);
    add(1,1,2'b01,0,8'h00, 8'h00,6,0);
    add(1,1,2'b01,0,8'h00, 8'h00,7,0);
    add(1,1,2'b01,0,8'h00, 8'h00,8,1);
    add(1,1,2'b00,0,8'h00, 8'h00,8,0);
    // Reset after six shifts discards the partial word.
    add(1,1,2'b11,0,8'h0F, 8'h0F,0,0);
    add(1,1,2'b10,0,8'h00, 8'h1E,1,0);
    add(1,1,2'b10,0,8'h00, 8'h3C,2,0);
    add(1,1,2'b10,0,8'h00, 8'h78,3,0);
    add(1,1,2'b10,0,8'h00, 8'hF0,4,0);
    add(1,1,2'b10,0,8'h00, 8'hE0,5,0);
    add(1,1,2'b10,0,8'h00, 8'hC0,6,0);
    add(0,1,2'b10,0,8'h00, 8'hA5,0,0);
    add(1,1,2'b01,1,8'h00, 8'hD2,1,0);
    add(1,1,2'b01,1,8'h00, 8'hE9,2,0);
    add(1,1,2'b01,1,8'h00, 8'hF4,3,0);
    add(1,1,2'b01,1,8'h00, 8'hFA,4,0);
    add(1,1,2'b01,1,8'h00, 8'hFD,5,0);
    add(1,1,2'b01,1,8'h00, 8'hFE,6,0);
    add(1,1,2'b01,1,8'h00, 8'hFF,7,0);
    add(1,1,2'b01,1,8'h00, 8'hFF,8,1);
    // Load of 0x3C while word_done is high: pulse still one cycle, counter restarts.
    add(1,1,2'b11,0,8'h3C, 8'h3C,0,0);
    add(1,1,2'b00,0,8'h00, 8'h3C,0,0);

    foreach (vecs[i]) begin
      step8(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].sin, vecs[i].d);
      $display("vec %0d: rst=%0b en=%0b mode=%0d sin=%0b d=%02h -> q=%02h cnt=%0d done=%0b",
               i, vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].sin, vecs[i].d,
               bus8.q, bus8.cnt, bus8.word_done);
      check8($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_done);
    end

    // Pulse is not stretched when en drops right after the completing shift.
    step8(1,1,2'b11,0,8'h00);
    for (int k = 1; k <= 8; k++) begin
      step8(1,1,2'b10,1'b1,8'h00);
    end
    $display("seq en-drop: after 8th shift q=%02h cnt=%0d done=%0b", bus8.q, bus8.cnt, bus8.word_done);
    check8("endrop_pulse", 8'hFF, 4'd8, 1'b1);
    step8(1,0,2'b10,1'b0,8'h00);
    $display("seq en-drop: en=0 edge q=%02h cnt=%0d done=%0b", bus8.q, bus8.cnt, bus8.word_done);
    check8("endrop_after", 8'hFF, 4'd8, 1'b0);

    // Legacy 4-bit chain: a single 1 on sin reaches sout_msb after 4 left shifts.
    @(negedge clk);
    rst = 1'b0; bus8.en = 1'b0; bus4.en = 1'b0;
    @(posedge clk); #1;
    chk("legacy_reset_q", 32'(bus4.q), 32'h0);
    lpat = 8'b0000_1000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rst = 1'b1; bus4.en = 1'b1; bus4.mode = 2'b10;
      bus4.sin = (k == 1);
      @(posedge clk); #1;
      $display("legacy edge %0d: sin=%0b q=%01h cnt=%0d done=%0b sout_msb=%0b",
               k, bus4.sin, bus4.q, bus4.cnt, bus4.word_done, bus4.sout_msb);
      chk($sformatf("legacy%0d.sout_msb", k), 32'(bus4.sout_msb), 32'(lpat[k-1]));
      chk($sformatf("legacy%0d.cnt", k), 32'(bus4.cnt), (k >= 4) ? 32'd4 : 32'(k));
      chk($sformatf("legacy%0d.word_done", k), 32'(bus4.word_done), (k == 4) ? 32'd1 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register built on the team's synchronous-flop style. Successor to the fixed 4-bit serial-in/serial-out chain.
- Adds configurable width, left/right shifting, parallel load, parallel readout, and a shift counter with a one-cycle word-complete pulse.
- Used as the serializer/deserializer stage between the datapath and bit-serial lab peripherals.

Parameters:
- WIDTH, 8, register length in bits; legal range 2..32.
- RST_VAL, 0, value loaded into q on reset; WIDTH bits.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-low (0 = reset, sampled on rising clk).
- en  input  1  clock enable; 0 = hold all state, including the counter.
- mode  input  2  00 hold, 01 shift right (toward bit 0), 10 shift left (toward bit WIDTH-1), 11 parallel load.
- sin  input  1  serial input bit, inserted at the vacated end on a shift.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_lsb  output  1  q[0], combinational from the register.
- sout_msb  output  1  q[WIDTH-1], combinational from the register.
- cnt  output  $clog2(WIDTH+1)  number of shifts since the last load or reset; saturates at WIDTH.
- word_done  output  1  registered one-cycle pulse; high in the cycle after the shift that brings cnt to WIDTH.

Behaviour:
- All state changes only on the rising edge of clk. There are no asynchronous paths.
- Priority order: rst=0, then en=0, then mode.
- Reset (rst=0 at an edge):
  - q <= RST_VAL, cnt <= 0, word_done <= 0.
  - Overrides en and mode.
  - Reset mid-sequence discards the partial word; no word_done is produced for it.
- en=0: q and cnt hold; word_done <= 0. A pending pulse is never stretched or delayed.
- mode 00: q and cnt hold; word_done <= 0.
- mode 01: q <= {sin, q[WIDTH-1:1]}. The bit shifted out is the pre-edge q[0], visible on sout_lsb before the edge.
- mode 10: q <= {q[WIDTH-2:0], sin}. The bit shifted out is the pre-edge q[WIDTH-1].
- mode 11: q <= d; cnt <= 0; word_done <= 0.
- Counter on a shift (mode 01 or 10):
  - If cnt < WIDTH: cnt <= cnt+1.
  - If cnt == WIDTH: cnt holds at WIDTH.
- word_done <= 1 only when a shift occurs with pre-edge cnt == WIDTH-1. Otherwise word_done <= 0.
  - Exactly one pulse per word.
  - Further shifts after saturation produce no additional pulses until a load or reset.
- Direction changes mid-word are legal and still count as shifts.
- A load in the same cycle that word_done is high is legal. The pulse completes normally and the counter restarts at 0.
- Latency: q, cnt and word_done reflect an edge's operation immediately after that edge. sout_* follow q with zero added cycles.
- WIDTH=4 with mode fixed at 10 and sin as serial input is bit-equivalent to the legacy 4-bit chain. Output is sout_msb, with 4 cycles from sin to sout_msb.

Test Plan:
- Reset: WIDTH=8, RST_VAL=8'hA5, hold rst=0 for 2 edges with mode=11, d=8'hFF -> q=8'hA5, cnt=0, word_done=0; rst has priority.
- Load then right-shift: load d=8'h81, then 8 edges of mode=01 with sin=0.
  - sout_lsb sequence before each edge: 1,0,0,0,0,0,0,1.
  - After the 8th edge: q=8'h00, cnt=8, word_done=1 for exactly one cycle.
- Left-shift deserialize: from reset (RST_VAL=0), mode=10, sin pattern 1,0,1,1,0,0,1,0 -> q=8'hB2 after 8 edges; word_done pulses once; a 9th shift gives cnt=8 and no pulse.
- Enable gating: mid-word with cnt=3, drop en for 5 cycles while toggling mode and sin -> q and cnt unchanged; then 5 more shifts -> word_done pulses after the 5th.
- Reset mid-operation: after 6 shifts, rst=0 for 1 edge, then 8 shifts -> exactly one word_done, on the 8th post-reset shift.
- Load during pulse: load d=8'h3C in the cycle word_done=1 -> q=8'h3C, cnt=0, pulse is one cycle wide; legacy check with WIDTH=4, mode=10 shows a 4-cycle sin-to-sout_msb delay.
